fft_unloader: RTL and testbench

FFT_UNLOADER -- requirements
Module: fft_unloader

---
 rtl/fft_pkg.sv | 19 +
 rtl/fft_unloader_if.sv | 14 +
 rtl/fft_out_fifo.sv | 41 ++++
 rtl/fft_unloader.sv | 102 ++++++++++
 tb/tb_fft_unloader.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared FFT sizing, complex sample type and bit-reverse helper used by the
// frame unloader and its address generation.
package fft_pkg;
  localparam int FFT_N     = 1024;
  localparam int FFT_LOG2N = 10;
  localparam int FFT_DW    = 32;

  // Signed Q16.16 complex sample; "real" is a keyword, so fields are re/im.
  typedef struct packed {
    logic signed [FFT_DW-1:0] re;
    logic signed [FFT_DW-1:0] im;
  } complex_t;

  function automatic logic [FFT_LOG2N-1:0] bit_reverse(input logic [FFT_LOG2N-1:0] idx);
    logic [FFT_LOG2N-1:0] r;
    for (int b = 0; b < FFT_LOG2N; b++) r[b] = idx[FFT_LOG2N-1-b];
    return r;
  endfunction
endpackage

// File: rtl/fft_unloader_if.sv
// Output sample stream of the FFT unloader.
// Handshake: a sample transfers on a rising edge where out_valid && out_ready;
// once out_valid is high, out_real/out_imag/out_last hold until that transfer.
interface fft_unloader_if;
  import fft_pkg::*;
  logic [FFT_DW-1:0] out_real;
  logic [FFT_DW-1:0] out_imag;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (output out_real, out_imag, out_valid, out_last, input out_ready);
  modport slave  (input out_real, out_imag, out_valid, out_last, output out_ready);
endinterface

// File: rtl/fft_out_fifo.sv
// Two-entry skid FIFO holding read-back samples until the downstream accepts them.
module fft_out_fifo #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         push_ok;
  logic         pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end
endmodule

// File: rtl/fft_unloader.sv
// Streams a finished FFT frame out of fft_ram in natural bin order.
// Optional `FFT_UNLOAD_SCALE_EN: divide each output by N (arithmetic shift).
module fft_unloader
  import fft_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [FFT_LOG2N-1:0] ram_index,
  output logic                 ram_rd_en,
  input  logic [FFT_DW-1:0]    ram_real_i,
  input  logic [FFT_DW-1:0]    ram_imag_i,
  fft_unloader_if.master       stream,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           fsm_state
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;
  localparam logic [FFT_LOG2N-1:0] J_LAST = FFT_LOG2N'(FFT_N - 1);
  localparam int FW = 1 + 2 * FFT_DW;

  logic [1:0]           state;
  logic [FFT_LOG2N-1:0] j;
  logic                 rd_q;
  logic                 rd_last_q;
  logic                 rd_en;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [1:0]           occ;
  logic [2:0]           credit_use;
  complex_t             sample_in;
  complex_t             head;
  logic                 head_last;
  logic [FW-1:0]        head_raw;

`ifdef FFT_UNLOAD_SCALE_EN
  assign sample_in.re = $signed(ram_real_i) >>> FFT_LOG2N;
  assign sample_in.im = $signed(ram_imag_i) >>> FFT_LOG2N;
`else
  assign sample_in.re = ram_real_i;
  assign sample_in.im = ram_imag_i;
`endif

  // A read is allowed only if the entries left after this cycle's pop plus
  // the read still in flight leave room, so the FIFO can never overflow.
  assign occ        = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
  assign pop        = stream.out_valid && stream.out_ready;
  assign credit_use = {1'b0, occ} + {2'b0, rd_q} - {2'b0, pop};
  assign rd_en      = (state == S_STREAM) && (credit_use < 3'd2);

  assign ram_rd_en  = rd_en;
  assign ram_index  = bit_reverse(j);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_FINISH);
  assign fsm_state  = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      j         <= '0;
      rd_q      <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      rd_q      <= rd_en;
      rd_last_q <= rd_en && (j == J_LAST);
      if (rd_en) j <= j + 1'b1;
      case (state)
        S_IDLE: if (start) begin
          state <= S_STREAM;
          j     <= '0;
        end
        S_STREAM: if (rd_en && (j == J_LAST)) state <= S_DRAIN;
        S_DRAIN:  if (pop && head_last) state <= S_FINISH;
        default:  state <= S_IDLE;
      endcase
    end
  end

  fft_out_fifo #(.W(FW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_q),
    .wdata ({rd_last_q, sample_in}),
    .pop   (pop),
    .rdata (head_raw),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_last = head_raw[FW-1];
  assign head      = complex_t'(head_raw[FW-2:0]);

  // Gate with empty so stale FIFO contents never show after reset.
  assign stream.out_valid = !fifo_empty;
  assign stream.out_real  = fifo_empty ? '0 : head.re;
  assign stream.out_imag  = fifo_empty ? '0 : head.im;
  assign stream.out_last  = !fifo_empty && head_last;
endmodule

// File: tb/tb_fft_unloader.sv
// Self-checking bench for fft_unloader: RAM model, ready driver, scoreboard.
module tb_fft_unloader;
  import fft_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  ram_index;
  logic        ram_rd_en;
  logic [31:0] ram_real_i = '0;
  logic [31:0] ram_imag_i = '0;
  logic        busy;
  logic        done;
  logic [1:0]  fsm_state;

  fft_unloader_if sif ();

  fft_unloader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ram_index  (ram_index),
    .ram_rd_en  (ram_rd_en),
    .ram_real_i (ram_real_i),
    .ram_imag_i (ram_imag_i),
    .stream     (sif.master),
    .busy       (busy),
    .done       (done),
    .fsm_state  (fsm_state)
  );

  always #5 clk = ~clk;

  // ---------------- RAM model (registered read) ----------------
  logic [31:0] ram_re [1024];
  logic [31:0] ram_im [1024];
  always @(posedge clk) begin
    if (ram_rd_en) begin
      ram_real_i <= ram_re[ram_index];
      ram_imag_i <= ram_im[ram_index];
    end
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rev10(input int k);
    int r = 0;
    for (int i = 0; i < 10; i++) if (k & (1 << i)) r = r | (1 << (9 - i));
    return r;
  endfunction

  function automatic logic [31:0] scale(input logic [31:0] v);
`ifdef FFT_UNLOAD_SCALE_EN
    return 32'($signed(v) >>> 10);
`else
    return v;
`endif
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [64:0] exp_q[$];
  logic [64:0] mon_e;
  logic [64:0] prev_data;
  logic        prev_stall = 1'b0;
  logic        prev_rst = 1'b1;
  logic [31:0] first_re;
  int ncyc = 0, hs_cnt = 0, rd_cnt = 0, max_out = 0, done_cnt = 0, n_busy = 0;
  int t_start = -1, t_rd = -1, t_valid = -1, t_last = -1, t_done = -1, t_busy = -1;
  int rdy_mode = 0;

  task automatic frame_reset();
    exp_q.delete();
    hs_cnt = 0; rd_cnt = 0; max_out = 0; done_cnt = 0; n_busy = 0;
    t_start = -1; t_rd = -1; t_valid = -1; t_last = -1; t_done = -1; t_busy = -1;
    first_re = '0;
    for (int k = 0; k < 1024; k++)
      exp_q.push_back({(k == 1023), scale(ram_re[rev10(k)]), scale(ram_im[rev10(k)])});
  endtask

  always @(negedge clk) begin
    ncyc++;
    if (!rst) begin
      if (start && !busy && t_start < 0) t_start = ncyc;
      if (ram_rd_en) begin
        rd_cnt++;
        if (t_rd < 0) t_rd = ncyc;
      end
      if (sif.out_valid && t_valid < 0) t_valid = ncyc;
      if (busy) begin
        n_busy++;
        if (t_busy < 0) t_busy = ncyc;
      end
      if (done) begin
        done_cnt++;
        t_done = ncyc;
      end
      if (prev_stall && !prev_rst) begin
        check("hold_valid", 64'(sif.out_valid), 64'd1);
        check("hold_data", {sif.out_real, sif.out_imag}, prev_data[63:0]);
        check("hold_last", 64'(sif.out_last), 64'(prev_data[64]));
      end
      if (sif.out_valid && sif.out_ready) begin
        if (hs_cnt == 0) first_re = sif.out_real;
        hs_cnt++;
        if (sif.out_last) t_last = ncyc;
        if (exp_q.size() == 0) begin
          check("extra_sample", 64'(hs_cnt), 64'd1024);
        end else begin
          mon_e = exp_q.pop_front();
          check("real", 64'(sif.out_real), 64'(mon_e[63:32]));
          check("imag", 64'(sif.out_imag), 64'(mon_e[31:0]));
          check("last", 64'(sif.out_last), 64'(mon_e[64]));
        end
      end
      if (rd_cnt - hs_cnt > max_out) max_out = rd_cnt - hs_cnt;
    end
    prev_stall = sif.out_valid && !sif.out_ready;
    prev_data  = {sif.out_last, sif.out_real, sif.out_imag};
    prev_rst   = rst;
  end

  // ---------------- drivers ----------------
  initial begin
    sif.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: sif.out_ready = 1'b1;
        1: sif.out_ready = 1'($urandom_range(0, 1));
        default: sif.out_ready = 1'b0;
      endcase
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (done_cnt == 0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    check("frame_done", 64'(done_cnt), 64'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input int n, input int budget);
    int c = 0;
    while (hs_cnt < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    #1;
    check("hs_reached", 64'(hs_cnt >= n), 64'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_index"}, 64'(ram_index), 64'd0);
    check({tag, "_rd_en"}, 64'(ram_rd_en), 64'd0);
    check({tag, "_valid"}, 64'(sif.out_valid), 64'd0);
    check({tag, "_data"}, {sif.out_real, sif.out_imag}, 64'd0);
    check({tag, "_last"}, 64'(sif.out_last), 64'd0);
    check({tag, "_busy_done"}, {62'd0, busy, done}, 64'd0);
  endtask

  task automatic end_of_frame_checks(input string tag);
    check({tag, "_hs_count"}, 64'(hs_cnt), 64'd1024);
    check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_outstanding_le2"}, 64'(max_out <= 2), 64'd1);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int c;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Frame 1: ramp data, ready always high, exact latency.
    for (int i = 0; i < 1024; i++) begin
      ram_re[i] = 32'(i);
      ram_im[i] = 32'(-i);
    end
    rdy_mode = 0;
    frame_reset();
    pulse_start();
    wait_done(3000);
    check("lat_first_rd", 64'(t_rd - t_start), 64'd1);
    check("lat_first_valid", 64'(t_valid - t_start), 64'd3);
    check("lat_last", 64'(t_last - t_start), 64'd1026);
    check("lat_done", 64'(t_done - t_start), 64'd1027);
    check("contiguous", 64'(t_last - t_valid), 64'd1023);
    check("busy_rise", 64'(t_busy - t_start), 64'd1);
    check("busy_cycles", 64'(n_busy), 64'd1027);
    check("f1_first_real", 64'(first_re), 64'(scale(32'd0)));
    end_of_frame_checks("f1");

    // Frame 2: random data, 50% ready, start pulsed mid-frame.
    for (int i = 0; i < 1024; i++) begin
      ram_re[i] = $urandom;
      ram_im[i] = $urandom;
    end
    ram_re[0] = 32'hFFFF0000;
    rdy_mode = 1;
    frame_reset();
    pulse_start();
    wait_hs(300, 2000);
    pulse_start();
    wait_done(6000);
    end_of_frame_checks("f2");
`ifdef FFT_UNLOAD_SCALE_EN
    check("scale_minus_one", 64'(first_re), 64'h0000_0000_FFFF_FFC0);
`else
    check("scale_minus_one", 64'(first_re), 64'h0000_0000_FFFF_0000);
`endif
    repeat (20) @(posedge clk);
    #1;
    check("f2_frame_count", 64'(done_cnt), 64'd1);
    check("f2_no_restart", 64'(busy), 64'd0);

    // Frame 3: downstream stalled for 100 cycles after the first valid.
    rdy_mode = 2;
    frame_reset();
    pulse_start();
    c = 0;
    while (t_valid < 0 && c < 50) begin
      @(posedge clk);
      c++;
    end
    check("f3_valid_seen", 64'(t_valid >= 0), 64'd1);
    repeat (100) @(posedge clk);
    #1;
    check("f3_stall_reads", 64'(rd_cnt), 64'd2);
    check("f3_stall_hs", 64'(hs_cnt), 64'd0);
    rdy_mode = 0;
    wait_done(3000);
    end_of_frame_checks("f3");

    // Frame 4: reset at the 500th handshake, then a fresh frame.
    rdy_mode = 1;
    frame_reset();
    pulse_start();
    wait_hs(500, 4000);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_idle("midrst");
    frame_reset();
    pulse_start();
    wait_done(6000);
    check("restart_k0", 64'(first_re), 64'(scale(ram_re[0])));
    end_of_frame_checks("f5");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
